// File: rtl/sfx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sfx_sequencer
// Function : Multi-effect square-wave sound-effect sequencer driven by
//            one-cycle game triggers and fed from an internal note table.
// Revision : 1.0 - initial release
// ============================================================================
module sfx_sequencer #(
    parameter int CLOCK_FREQUENCY  = 50000000,
    parameter int NUM_EFFECTS      = 4,
    parameter int NOTES_PER_EFFECT = 4,
    parameter int NOTE_CYCLES      = CLOCK_FREQUENCY / 8,
    parameter int GAP_CYCLES       = CLOCK_FREQUENCY / 100,
    parameter int SAMPLE_WIDTH     = 32,
    parameter int AMPLITUDE        = 10000000
) (
    input  logic                    clk,
    input  logic                    iReset,
    input  logic                    iEn,
    input  logic [NUM_EFFECTS-1:0]  iTrigger,
    input  logic [1:0]              iVolume,
    output logic [SAMPLE_WIDTH-1:0] oSample,
    output logic                    oActive,
    output logic [2:0]              oEffect,
    output logic                    oDone
);

    // Frequencies are carried in centi-Hz so 523.25 Hz and 659.26 Hz stay exact.
    function automatic logic [63:0] calc_hp(input logic [63:0] centi_hz);
        logic [63:0] v;
        v = (64'(CLOCK_FREQUENCY) * 64'd100) / (64'd2 * centi_hz);
        if (v < 64'd1) v = 64'd1;
        return v;
    endfunction

    localparam logic [63:0] HP_A4_L = calc_hp(64'd44000);
    localparam logic [63:0] HP_C5_L = calc_hp(64'd52325);
    localparam logic [63:0] HP_E5_L = calc_hp(64'd65926);
    localparam logic [63:0] HP_A5_L = calc_hp(64'd88000);
    localparam int          HP_W    = $clog2(HP_A4_L + 64'd1);
    localparam logic [HP_W-1:0] HP_A4 = HP_A4_L[HP_W-1:0];
    localparam logic [HP_W-1:0] HP_C5 = HP_C5_L[HP_W-1:0];
    localparam logic [HP_W-1:0] HP_E5 = HP_E5_L[HP_W-1:0];
    localparam logic [HP_W-1:0] HP_A5 = HP_A5_L[HP_W-1:0];

    localparam int DUR_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int DUR_W   = $clog2(DUR_MAX + 1);
    localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_CYCLES - 1);
    localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [3:0]       NOTES_L   = 4'(NOTES_PER_EFFECT);
    localparam logic signed [SAMPLE_WIDTH-1:0] AMP_S = SAMPLE_WIDTH'(AMPLITUDE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Half-period code 0 marks the end of an effect; effects >= 4 reuse rotate.
    function automatic logic [HP_W-1:0] note_hp(input logic [2:0] eff, input logic [2:0] idx);
        logic [HP_W-1:0] hp;
        hp = '0;
        case (eff)
            3'd0: begin
                case (idx)
                    3'd0:    hp = HP_A4;
                    3'd1:    hp = HP_C5;
                    3'd2:    hp = HP_E5;
                    3'd3:    hp = HP_A5;
                    default: hp = '0;
                endcase
            end
            3'd1: hp = (idx == 3'd0) ? HP_E5 : '0;
            3'd2: begin
                case (idx)
                    3'd0:    hp = HP_E5;
                    3'd1:    hp = HP_C5;
                    3'd2:    hp = HP_A4;
                    3'd3:    hp = HP_A4;
                    default: hp = '0;
                endcase
            end
            default: hp = (idx == 3'd0) ? HP_A5 : '0;
        endcase
        return hp;
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        eff_q, eff_d;
    logic [2:0]        idx_q, idx_d;
    logic [HP_W-1:0]   per_q, per_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              phase_q, phase_d;
    logic              done_q, done_d;

    logic [SAMPLE_WIDTH-1:0] sample_q;
    logic                    active_q;
    logic [2:0]              effect_q;
    logic                    done_out_q;

    logic [7:0]        trig_w;
    logic [2:0]        sel_w;
    logic [HP_W-1:0]   cur_hp_w;
    logic [HP_W-1:0]   nxt_hp_w;
    logic              last_w;
    logic              completing_w;
    logic              accept_w;
    logic signed [SAMPLE_WIDTH-1:0] mag_w;

    always_comb begin
        trig_w                   = '0;
        trig_w[NUM_EFFECTS-1:0]  = iTrigger;
        sel_w                    = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (trig_w[i]) sel_w = 3'(i);
        end
    end

    assign cur_hp_w     = note_hp(eff_q, idx_q);
    assign nxt_hp_w     = note_hp(eff_q, idx_q + 3'd1);
    assign last_w       = (({1'b0, idx_q} + 4'd1) == NOTES_L) || (nxt_hp_w == '0);
    assign completing_w = (state_q == S_PLAY) && (dur_q == NOTE_LAST) && last_w;
    // Equal-or-higher priority pre-empts; anything is taken on natural completion.
    assign accept_w     = (trig_w != 8'd0) &&
                          ((state_q == S_IDLE) || (sel_w <= eff_q) || completing_w);
    assign mag_w        = AMP_S >>> iVolume;

    always_comb begin
        state_d = state_q;
        eff_d   = eff_q;
        idx_d   = idx_q;
        per_d   = per_q;
        dur_d   = dur_q;
        phase_d = phase_q;
        done_d  = 1'b0;

        case (state_q)
            S_PLAY: begin
                if (per_q == cur_hp_w - HP_W'(1)) begin
                    per_d   = '0;
                    phase_d = ~phase_q;
                end else begin
                    per_d = per_q + HP_W'(1);
                end
                if (dur_q == NOTE_LAST) begin
                    dur_d = '0;
                    if (last_w) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (GAP_CYCLES == 0) begin
                        idx_d   = idx_q + 3'd1;
                        per_d   = '0;
                        phase_d = 1'b0;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    dur_d = dur_q + DUR_W'(1);
                end
            end
            S_GAP: begin
                if (dur_q == GAP_LAST) begin
                    state_d = S_PLAY;
                    idx_d   = idx_q + 3'd1;
                    per_d   = '0;
                    dur_d   = '0;
                    phase_d = 1'b0;
                end else begin
                    dur_d = dur_q + DUR_W'(1);
                end
            end
            default: ;
        endcase

        if (accept_w) begin
            state_d = S_PLAY;
            eff_d   = sel_w;
            idx_d   = 3'd0;
            per_d   = '0;
            dur_d   = '0;
            phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            state_q    <= S_IDLE;
            eff_q      <= 3'd0;
            idx_q      <= 3'd0;
            per_q      <= '0;
            dur_q      <= '0;
            phase_q    <= 1'b0;
            done_q     <= 1'b0;
            sample_q   <= '0;
            active_q   <= 1'b0;
            effect_q   <= 3'd0;
            done_out_q <= 1'b0;
        end else if (iEn) begin
            state_q    <= state_d;
            eff_q      <= eff_d;
            idx_q      <= idx_d;
            per_q      <= per_d;
            dur_q      <= dur_d;
            phase_q    <= phase_d;
            done_q     <= done_d;
            sample_q   <= (state_q == S_PLAY) ? (phase_q ? -mag_w : mag_w) : '0;
            active_q   <= (state_q != S_IDLE);
            effect_q   <= eff_q;
            done_out_q <= done_q;
        end
    end

    // A frozen pipeline keeps its last values, so mute and block the pulse meanwhile.
    assign oSample = iEn ? sample_q : '0;
    assign oActive = active_q;
    assign oEffect = effect_q;
    assign oDone   = done_out_q & iEn;

endmodule
`default_nettype wire

// File: tb/tb_sfx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfx_sequencer
// Function : Directed and random stimulus for sfx_sequencer against a
//            duration/phase arithmetic model of the effect timeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sfx_sequencer;

    localparam int CF        = 8000;
    localparam int NOTE      = 30;
    localparam int GAP       = 4;
    localparam int NOTES     = 4;
    localparam int AMPLITUDE = 10000000;

    logic        clk = 1'b0;
    logic        iReset;
    logic        iEn;
    logic [3:0]  iTrigger;
    logic [1:0]  iVolume;
    logic [31:0] oSample;
    logic        oActive;
    logic [2:0]  oEffect;
    logic        oDone;

    always #5 clk = ~clk;

    sfx_sequencer #(
        .CLOCK_FREQUENCY (CF),
        .NUM_EFFECTS     (4),
        .NOTES_PER_EFFECT(NOTES),
        .NOTE_CYCLES     (NOTE),
        .GAP_CYCLES      (GAP),
        .SAMPLE_WIDTH    (32),
        .AMPLITUDE       (AMPLITUDE)
    ) dut (
        .clk     (clk),
        .iReset  (iReset),
        .iEn     (iEn),
        .iTrigger(iTrigger),
        .iVolume (iVolume),
        .oSample (oSample),
        .oActive (oActive),
        .oEffect (oEffect),
        .oDone   (oDone)
    );

    int checks = 0;
    int errors = 0;

    // Reference timeline: an effect is just (effect id, cycles elapsed since start).
    bit m_active;
    int m_eff;
    int m_t;
    bit m_done;
    int e_sample;
    bit e_active;
    int e_eff;
    bit e_done;
    int act_cnt;
    int done_cnt;

    function automatic int bhp(input int e, input int k);
        real f;
        int  h;
        int  ee;
        ee = (e >= 4) ? 3 : e;
        f  = 0.0;
        if (k < 4) begin
            case (ee)
                0: f = (k == 0) ? 440.0 : (k == 1) ? 523.25 : (k == 2) ? 659.26 : 880.0;
                1: f = (k == 0) ? 659.26 : 0.0;
                2: f = (k == 0) ? 659.26 : (k == 1) ? 523.25 : 440.0;
                default: f = (k == 0) ? 880.0 : 0.0;
            endcase
        end
        if (f == 0.0) return 0;
        h = $rtoi(CF / (2.0 * f));
        return (h < 1) ? 1 : h;
    endfunction

    function automatic int nnotes(input int e);
        int n;
        n = 0;
        while (n < NOTES && bhp(e, n) != 0) n++;
        return n;
    endfunction

    function automatic int dur(input int e);
        return nnotes(e) * NOTE + (nnotes(e) - 1) * GAP;
    endfunction

    function automatic int smp(input int e, input int t, input int vol);
        int k;
        int o;
        int mag;
        k   = t / (NOTE + GAP);
        o   = t % (NOTE + GAP);
        mag = AMPLITUDE >>> vol;
        if (o >= NOTE) return 0;
        return (((o / bhp(e, k)) % 2) == 1) ? -mag : mag;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_eff = 0; m_t = 0; m_done = 0;
        e_sample = 0; e_active = 0; e_eff = 0; e_done = 0;
    endtask

    task automatic step(input logic [3:0] trig, input logic en, input logic [1:0] vol);
        bit completing;
        int w;
        @(negedge clk);
        iTrigger = trig;
        iEn      = en;
        iVolume  = vol;
        @(posedge clk);
        if (en) begin
            e_sample   = m_active ? smp(m_eff, m_t, int'(vol)) : 0;
            e_active   = m_active;
            e_eff      = m_eff;
            e_done     = m_done;
            completing = m_active && (m_t + 1 == dur(m_eff));
            m_done     = completing;
            w = -1;
            for (int i = 3; i >= 0; i--) if (trig[i]) w = i;
            if (w >= 0 && (!m_active || w <= m_eff || completing)) begin
                m_active = 1; m_eff = w; m_t = 0;
            end else if (completing) begin
                m_active = 0;
            end else if (m_active) begin
                m_t++;
            end
        end
        #1;
        chk("sample", oSample, en ? 32'(e_sample) : 32'd0);
        chk("active", {31'd0, oActive}, {31'd0, e_active});
        chk("effect", {29'd0, oEffect}, 32'(e_eff));
        chk("done",   {31'd0, oDone},   {31'd0, e_done & en});
        if (oActive === 1'b1) act_cnt++;
        if (oDone === 1'b1) done_cnt++;
    endtask

    task automatic run(input int n, input logic [1:0] vol);
        for (int i = 0; i < n; i++) step(4'd0, 1'b1, vol);
    endtask

    initial begin
        iReset = 1'b1; iEn = 1'b0; iTrigger = '0; iVolume = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sample", oSample, 32'd0);
        chk("rst_active", {31'd0, oActive}, 32'd0);
        chk("rst_effect", {29'd0, oEffect}, 32'd0);
        chk("rst_done",   {31'd0, oDone},   32'd0);
        @(negedge clk);
        iReset = 1'b0;

        run(100, 2'd0);

        // Move: one note, then completion.
        act_cnt = 0; done_cnt = 0;
        step(4'b0010, 1'b1, 2'd0);
        run(dur(1) + 3, 2'd0);
        chk("move_len",  32'(act_cnt),  32'(NOTE));
        chk("move_done", 32'(done_cnt), 32'd1);

        // Line clear: four notes with gaps between them only.
        act_cnt = 0; done_cnt = 0;
        step(4'b0001, 1'b1, 2'd0);
        run(4 * NOTE + 3 * GAP + 3, 2'd0);
        chk("clear_len",  32'(act_cnt),  32'(4 * NOTE + 3 * GAP));
        chk("clear_done", 32'(done_cnt), 32'd1);

        // Rotate pre-empted by line clear; lower-priority rotate then dropped.
        done_cnt = 0;
        step(4'b1000, 1'b1, 2'd0);
        run(10, 2'd0);
        step(4'b0001, 1'b1, 2'd0);
        step(4'b0000, 1'b1, 2'd0);
        chk("preempt_eff", {29'd0, oEffect}, 32'd0);
        chk("preempt_pos", oSample, 32'(AMPLITUDE));
        run(5, 2'd0);
        step(4'b1000, 1'b1, 2'd0);
        run(dur(0), 2'd0);
        chk("preempt_done", 32'(done_cnt), 32'd1);

        // Game over with a mid-note enable drop.
        act_cnt = 0;
        step(4'b0100, 1'b1, 2'd0);
        run(10, 2'd0);
        for (int i = 0; i < 50; i++) step(4'b0001, 1'b0, 2'd0);
        run(dur(2) + 3, 2'd0);
        chk("pause_len", 32'(act_cnt), 32'(dur(2) + 50));

        // Quarter volume, then asynchronous reset mid-note.
        step(4'b0010, 1'b1, 2'd2);
        step(4'b0000, 1'b1, 2'd2);
        chk("vol2_mag", oSample, 32'd2500000);
        run(5, 2'd2);
        iReset = 1'b1;
        #1;
        chk("async_sample", oSample, 32'd0);
        chk("async_active", {31'd0, oActive}, 32'd0);
        model_reset();
        @(negedge clk);
        iReset = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] t;
            t = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            step(t, ($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)));
        end
        run(200, 2'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
